// File: rtl/mix_columns_seq.sv
// Sequential AES (Inv)MixColumns, one column per cycle, IDLE/BUSY/DONE.
// Define MIX_COLUMNS_INV_EN to build the inverse transform selected by i_inv.
module mix_columns_seq (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_state,
  input  logic         i_inv,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d;
  logic [31:0]  col_in, col_out;
  logic         accept;

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] col_fwd(
    input logic [31:0] c
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    d0 = xt(a0);
    d1 = xt(a1);
    d2 = xt(a2);
    d3 = xt(a3);
    return {d0 ^ d1 ^ a1 ^ a2 ^ a3,
            a0 ^ d1 ^ d2 ^ a2 ^ a3,
            a0 ^ a1 ^ d2 ^ d3 ^ a3,
            d0 ^ a0 ^ a1 ^ a2 ^ d3};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  logic inv_q, inv_d;

  // 9=x8^1, 11=x8^x2^1, 13=x8^x4^1, 14=x8^x4^x2
  function automatic logic [31:0] col_inv(
    input logic [31:0] c
  );
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    a[0] = c[31:24];
    a[1] = c[23:16];
    a[2] = c[15:8];
    a[3] = c[7:0];
    for (int i = 0; i < 4; i++) begin
      x2 = xt(a[i]);
      x4 = xt(x2);
      x8 = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  assign col_out = inv_q ? col_inv(col_in) : col_fwd(col_in);

  always_comb begin
    inv_d = inv_q;
    if (accept) inv_d = i_inv;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) inv_q <= 1'b0;
    else          inv_q <= inv_d;
  end
`else
  logic unused_inv;
  assign unused_inv = i_inv;
  assign col_out    = col_fwd(col_in);
`endif

  assign accept = (fsm_q == IDLE) && i_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fsm_q <= IDLE;
    else          fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (i_valid) fsm_d = BUSY;
      BUSY:    if (col_q == 2'd3) fsm_d = DONE;
      DONE:    if (i_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (fsm_q == IDLE) && i_rst_n;
    o_valid = (fsm_q == DONE);
    o_state = work_q;
  end

  always_comb begin
    unique case (col_q)
      2'd0:    col_in = work_q[127:96];
      2'd1:    col_in = work_q[95:64];
      2'd2:    col_in = work_q[63:32];
      default: col_in = work_q[31:0];
    endcase
  end

  // Working register: load on accept, overwrite one column per BUSY cycle
  always_comb begin
    work_d = work_q;
    col_d  = col_q;
    if (accept) begin
      work_d = i_state;
      col_d  = 2'd0;
    end else if (fsm_q == BUSY) begin
      col_d = col_q + 2'd1;
      unique case (col_q)
        2'd0:    work_d[127:96] = col_out;
        2'd1:    work_d[95:64]  = col_out;
        2'd2:    work_d[63:32]  = col_out;
        default: work_d[31:0]   = col_out;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      work_q <= '0;
      col_q  <= 2'd0;
    end else begin
      work_q <= work_d;
      col_q  <= col_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: vectors, latency,
// backpressure, input isolation and mid-flight reset.
module tb_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_valid;
  logic         ds_ready;
  logic [127:0] out_state;

  int n_chk;
  int n_pass;

  mix_columns_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_state (in_state),
    .i_inv   (in_inv),
    .o_valid (out_valid),
    .i_ready (ds_ready),
    .o_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] V1_IN =
    128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT =
    128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN =
    128'hd4d4d4d5_2d26314c_00000000_00000000;
  localparam logic [127:0] V2_OUT =
    128'hd5d5d7d6_4d7ebdf8_00000000_00000000;
  localparam logic [127:0] V1_OUT_FWD =
    128'hcd504506_9f494f1f_01010101_c6c6c6c6;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (out_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_rdy_wait"}, 128'(out_ready), 128'd1);
  endtask

  // Accept, scramble inputs, check latency, result and release
  task automatic run(
    input string        tag,
    input logic [127:0] din,
    input logic         inv,
    input logic [127:0] exp
  );
    wait_ready(tag);
    in_state = din;
    in_inv   = inv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_state = ~din;
    in_inv   = ~inv;
    check({tag, "_busy_rdy"}, 128'(out_ready), 128'd0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin
        check({tag, "_early_v"}, 128'(out_valid), 128'd0);
      end
      tick();
    end
    check({tag, "_lat_v"}, 128'(out_valid), 128'd1);
    check({tag, "_data"}, out_state, exp);
    check({tag, "_done_rdy"}, 128'(out_ready), 128'd0);
    if (ds_ready) begin
      tick();
      check({tag, "_rel_v"}, 128'(out_valid), 128'd0);
      check({tag, "_rel_rdy"}, 128'(out_ready), 128'd1);
    end
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_state = V1_IN;
    in_inv   = 1'b0;
    ds_ready = 1'b1;
    tick();
    check("rst_rdy", 128'(out_ready), 128'd0);
    check("rst_v", 128'(out_valid), 128'd0);
    check("rst_st", out_state, 128'd0);
    tick();
    check("rst_hold_st", out_state, 128'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("post_rst_rdy", 128'(out_ready), 128'd1);

    run("v1", V1_IN, 1'b0, V1_OUT);
    run("v2", V2_IN, 1'b0, V2_OUT);
`ifdef MIX_COLUMNS_INV_EN
    run("inv", V1_OUT, 1'b1, V1_IN);
`else
    run("inv", V1_OUT, 1'b1, V1_OUT_FWD);
`endif

    // Backpressure in DONE
    ds_ready = 1'b0;
    run("bp", V2_IN, 1'b0, V2_OUT);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_v", 128'(out_valid), 128'd1);
      check("bp_st", out_state, V2_OUT);
      check("bp_rdy", 128'(out_ready), 128'd0);
    end
    ds_ready = 1'b1;
    tick();
    check("bp_rel_rdy", 128'(out_ready), 128'd1);
    check("bp_rel_v", 128'(out_valid), 128'd0);

    // Reset while column 2 is pending
    wait_ready("mr");
    in_state = V1_IN;
    in_inv   = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mr_st", out_state, 128'd0);
    check("mr_v", 128'(out_valid), 128'd0);
    check("mr_rdy", 128'(out_ready), 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("mr_stale_v", 128'(out_valid), 128'd0);
    end
    check("mr_idle_rdy", 128'(out_ready), 128'd1);
    run("mr_next", V2_IN, 1'b0, V2_OUT);
    run("mr_v1", V1_IN, 1'b0, V1_OUT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
